// File: rtl/jt900h_div_ctl_if.sv
// Request/result bus of the divide sequencer plus its link to the shared divider.
// slave = the sequencer; master = execution unit and divider side.
interface jt900h_div_ctl_if;
  logic        req;
  logic        sign;
  logic        len;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        v;
  logic [31:0] div_op0;
  logic [15:0] div_op1;
  logic        div_len;
  logic        div_start;
  logic [15:0] div_quot;
  logic [15:0] div_rem;
  logic        div_busy;
  logic        div_v;

  modport slave (
    input  req, sign, len, dividend, divisor, div_quot, div_rem, div_busy, div_v,
    output busy, done, result, v, div_op0, div_op1, div_len, div_start
  );

  modport master (
    output req, sign, len, dividend, divisor, div_quot, div_rem, div_busy, div_v,
    input  busy, done, result, v, div_op0, div_op1, div_len, div_start
  );
endinterface

// File: rtl/jt900h_div_ctl.sv
// DIV/DIVS sequencer: feeds operand magnitudes to the unsigned divider, then
// restores signs, checks overflow and packs the register-ready result.
module jt900h_div_ctl (
  input  logic               clk,
  input  logic               rst,
  input  logic               cen,
  jt900h_div_ctl_if.slave    bus
);

  typedef enum logic [2:0] {IDLE, PREP, START, WAIT, FIX, DONE} state_t;

  state_t      state_q;
  logic        sign_q, len_q;
  logic [31:0] dvd_q;
  logic [15:0] dvs_q;
  logic        neg_quot_q, neg_rem_q;
  logic        busy_q, done_q, v_q, start_q, div_len_q;
  logic [31:0] result_q, op0_q;
  logic [15:0] op1_q;

  logic        sd, sv, dvs_zero_d, ovf_d;
  logic [15:0] dvd_lo_d, dvs_lo_d, q_fix_d, r_fix_d, lim_d;
  logic [31:0] mag_dvd_d, packed_d;
  logic [15:0] mag_dvs_d;

  always_comb begin
    sd         = len_q ? dvd_q[31] : dvd_q[15];
    sv         = len_q ? dvs_q[15] : dvs_q[7];
    dvd_lo_d   = (sign_q && sd) ? -dvd_q[15:0] : dvd_q[15:0];
    dvs_lo_d   = (sign_q && sv) ? -{8'h0, dvs_q[7:0]} : {8'h0, dvs_q[7:0]};
    mag_dvd_d  = {16'h0, dvd_lo_d};
    mag_dvs_d  = {8'h0, dvs_lo_d[7:0]};
    dvs_zero_d = (dvs_q[7:0] == 8'h0);
    if (len_q) begin
      mag_dvd_d  = (sign_q && sd) ? -dvd_q : dvd_q;
      mag_dvs_d  = (sign_q && sv) ? -dvs_q : dvs_q;
      dvs_zero_d = (dvs_q == 16'h0);
    end
    q_fix_d = neg_quot_q ? -bus.div_quot : bus.div_quot;
    r_fix_d = neg_rem_q  ? -bus.div_rem  : bus.div_rem;
    // A negative quotient may reach one step further than a positive one
    lim_d = len_q ? (neg_quot_q ? 16'h8000 : 16'h7FFF)
                  : (neg_quot_q ? 16'h0080 : 16'h007F);
    ovf_d = bus.div_v
          | (sign_q && (bus.div_quot > lim_d))
          | (!len_q && (bus.div_quot[15:8] != 8'h0));
    packed_d = len_q ? {r_fix_d, q_fix_d} : {16'h0, r_fix_d[7:0], q_fix_d[7:0]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sign_q     <= 1'b0;
      len_q      <= 1'b0;
      dvd_q      <= 32'h0;
      dvs_q      <= 16'h0;
      neg_quot_q <= 1'b0;
      neg_rem_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      v_q        <= 1'b0;
      start_q    <= 1'b0;
      div_len_q  <= 1'b0;
      result_q   <= 32'h0;
      op0_q      <= 32'h0;
      op1_q      <= 16'h0;
    end else if (cen) begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (bus.req) begin
            sign_q    <= bus.sign;
            len_q     <= bus.len;
            dvd_q     <= bus.dividend;
            dvs_q     <= bus.divisor;
            div_len_q <= bus.len;
            busy_q    <= 1'b1;
            state_q   <= PREP;
          end
        end
        PREP: begin
          neg_quot_q <= sign_q & (sd ^ sv);
          neg_rem_q  <= sign_q & sd;
          op0_q      <= mag_dvd_d;
          op1_q      <= mag_dvs_d;
          // Divide-by-zero never reaches the divider
          if (dvs_zero_d) begin
            v_q      <= 1'b1;
            result_q <= dvd_q;
            state_q  <= DONE;
          end else begin
            start_q  <= 1'b1;
            state_q  <= START;
          end
        end
        START: begin
          if (bus.div_busy) begin
            start_q <= 1'b0;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (!bus.div_busy) state_q <= FIX;
        end
        FIX: begin
          v_q      <= ovf_d;
          result_q <= ovf_d ? dvd_q : packed_d;
          state_q  <= DONE;
        end
        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.result    = result_q;
  assign bus.v         = v_q;
  assign bus.div_op0   = op0_q;
  assign bus.div_op1   = op1_q;
  assign bus.div_len   = div_len_q;
  assign bus.div_start = start_q;

endmodule

// File: tb/tb_jt900h_div_ctl.sv
// Bench for jt900h_div_ctl: arithmetic reference model, divider stand-in,
// a per-cycle compare process and directed vectors with literal results.
module tb_jt900h_div_ctl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cen = 1'b1;
  logic cen_toggle = 1'b0;
  int   tests = 0;
  int   fails = 0;

  jt900h_div_ctl_if bus();

  jt900h_div_ctl dut (
    .clk (clk),
    .rst (rst),
    .cen (cen),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [31:0] res;
    logic        v;
    logic [31:0] op0;
    logic [15:0] op1;
    logic        len;
    logic        zero;
    int          lat;
  } exp_t;

  exp_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: got event required none", name);
  endtask

  // Plain integer arithmetic: truncating division, remainder takes dividend sign
  function automatic void model(input logic s, input logic l, input logic [31:0] dd,
                                input logic [15:0] dv, output logic [31:0] res,
                                output logic v, output logic [31:0] op0,
                                output logic [15:0] op1, output logic zero);
    longint a, b, q, r, lo, hi, ma, mb;
    logic [63:0] qb, rb, mab, mbb;
    if (l) begin
      a = s ? longint'($signed(dd)) : longint'(dd);
      b = s ? longint'($signed(dv)) : longint'(dv);
      lo = s ? -32768 : 0;
      hi = s ? 32767 : 65535;
    end else begin
      a = s ? longint'($signed(dd[15:0])) : longint'(dd[15:0]);
      b = s ? longint'($signed(dv[7:0])) : longint'(dv[7:0]);
      lo = s ? -128 : 0;
      hi = s ? 127 : 255;
    end
    ma = (a < 0) ? -a : a;
    mb = (b < 0) ? -b : b;
    mab = ma;
    mbb = mb;
    op0 = mab[31:0];
    op1 = mbb[15:0];
    zero = (b == 0);
    if (zero) begin
      v = 1'b1;
      res = dd;
    end else begin
      q = a / b;
      r = a % b;
      qb = q;
      rb = r;
      v = (q < lo) || (q > hi);
      if (v) res = dd;
      else if (l) res = {rb[15:0], qb[15:0]};
      else res = {16'h0, rb[7:0], qb[7:0]};
    end
  endfunction

  // Divider stand-in: busy for nbusy cen cycles, rising one cen after start
  int nbusy = 3;
  int dcnt = 0;
  always @(posedge clk) begin
    logic [31:0] qq, rr;
    if (rst) begin
      bus.div_busy <= 1'b0;
      bus.div_v    <= 1'b0;
      bus.div_quot <= 16'h0;
      bus.div_rem  <= 16'h0;
      dcnt         <= 0;
    end else if (cen) begin
      if (bus.div_busy) begin
        if (dcnt == 1) bus.div_busy <= 1'b0;
        dcnt <= dcnt - 1;
      end else if (bus.div_start) begin
        if (bus.div_len) begin
          qq = bus.div_op0 / {16'h0, bus.div_op1};
          rr = bus.div_op0 % {16'h0, bus.div_op1};
          bus.div_v <= (qq > 32'h0000_FFFF);
        end else begin
          qq = {16'h0, bus.div_op0[15:0]} / {24'h0, bus.div_op1[7:0]};
          rr = {16'h0, bus.div_op0[15:0]} % {24'h0, bus.div_op1[7:0]};
          bus.div_v <= 1'b0;
        end
        bus.div_quot <= qq[15:0];
        bus.div_rem  <= rr[15:0];
        bus.div_busy <= 1'b1;
        dcnt         <= nbusy;
      end
    end
  end

  int   cen_cnt = 0;
  logic last_cen = 1'b0;
  logic last_rst = 1'b1;
  always @(posedge clk) begin
    if (cen) cen_cnt <= cen_cnt + 1;
    last_cen <= cen;
    last_rst <= rst;
  end

  always @(negedge clk) cen = cen_toggle ? ~cen : 1'b1;

  int          done_cnt = 0;
  int          acc_cnt = 0;
  logic [31:0] last_res = 32'h0;
  logic        last_v = 1'b0;
  logic        busy_p = 1'b0, done_p = 1'b0, start_p = 1'b0, dbusy_p = 1'b0;

  always @(negedge clk) begin
    exp_t e;
    if (last_rst) begin
      busy_p = 1'b0;
      done_p = 1'b0;
      start_p = 1'b0;
      dbusy_p = 1'b0;
    end else begin
      if (bus.busy && !busy_p) acc_cnt = cen_cnt;
      if (start_p) chk("start_hold_or_drop", {31'h0, bus.div_start}, {31'h0, !(dbusy_p && last_cen)});
      if (bus.div_start && !start_p) begin
        if (exp_q.size() == 0) fail_now("start_unexpected");
        else begin
          e = exp_q[0];
          if (e.zero) fail_now("start_on_zero_divisor");
          chk("div_op0", bus.div_op0, e.op0);
          chk("div_op1", {16'h0, bus.div_op1}, {16'h0, e.op1});
          chk("div_len", {31'h0, bus.div_len}, {31'h0, e.len});
        end
      end
      if (bus.done && !done_p) begin
        done_cnt++;
        if (exp_q.size() == 0) fail_now("spurious_done");
        else begin
          e = exp_q.pop_front();
          chk("result", bus.result, e.res);
          chk("v", {31'h0, bus.v}, {31'h0, e.v});
          chk("latency", cen_cnt - acc_cnt, e.lat);
          chk("busy_at_done", {31'h0, bus.busy}, 32'h0);
        end
        last_res = bus.result;
        last_v = bus.v;
        $display("[TB] done: result=%h v=%0b latency=%0d", bus.result, bus.v, cen_cnt - acc_cnt);
      end
      busy_p = bus.busy;
      done_p = bus.done;
      start_p = bus.div_start;
      dbusy_p = bus.div_busy;
    end
  end

  task automatic push_exp(input logic s, input logic l, input logic [31:0] dd,
                          input logic [15:0] dv, input int nb,
                          input logic [31:0] lit_res, input logic lit_v);
    exp_t e;
    model(s, l, dd, dv, e.res, e.v, e.op0, e.op1, e.zero);
    e.len = l;
    e.lat = e.zero ? 2 : nb + 5;
    chk("model_pin_result", e.res, lit_res);
    chk("model_pin_v", {31'h0, e.v}, {31'h0, lit_v});
    exp_q.push_back(e);
  endtask

  task automatic run_op(input logic s, input logic l, input logic [31:0] dd,
                        input logic [15:0] dv, input int nb,
                        input logic [31:0] lit_res, input logic lit_v, input logic glitch);
    int d0;
    push_exp(s, l, dd, dv, nb, lit_res, lit_v);
    nbusy = nb;
    d0 = done_cnt;
    @(negedge clk);
    bus.sign = s;
    bus.len = l;
    bus.dividend = dd;
    bus.divisor = dv;
    bus.req = 1'b1;
    for (int i = 0; i < 40 && !bus.busy; i++) @(negedge clk);
    if (!bus.busy) fail_now("accept_timeout");
    bus.req = 1'b0;
    if (glitch) begin
      @(negedge clk);
      bus.dividend = 32'h0000_0001;
      bus.divisor = 16'h0;
      bus.req = 1'b1;
      @(negedge clk);
      @(negedge clk);
      bus.req = 1'b0;
    end
    for (int i = 0; i < 300 && done_cnt == d0; i++) @(negedge clk);
    if (done_cnt == d0) begin
      fail_now("done_timeout");
      exp_q.delete();
    end else begin
      chk("dut_literal_result", last_res, lit_res);
      chk("dut_literal_v", {31'h0, last_v}, {31'h0, lit_v});
    end
    $display("[TB] op s=%0b l=%0b dd=%h dv=%h -> %h v=%0b", s, l, dd, dv, last_res, last_v);
    if (glitch) begin
      repeat (30) @(negedge clk);
      chk("no_second_done", done_cnt - d0, 1);
    end
  endtask

  typedef struct {
    logic s; logic l; logic [31:0] dd; logic [15:0] dv; int nb; logic [31:0] res; logic v;
  } vec_t;
  vec_t vecs[13];

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 32'd125,       16'd7,      3, 32'h0006_0011, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h0000_FF83, 16'h0007,   2, 32'h0000_FAEF, 1'b0};
    vecs[2]  = '{1'b0, 1'b1, 32'h1234_5678, 16'h0000,   1, 32'h1234_5678, 1'b1};
    vecs[3]  = '{1'b0, 1'b0, 32'h0000_1000, 16'h0002,   2, 32'h0000_1000, 1'b1};
    vecs[4]  = '{1'b1, 1'b1, 32'h0000_8000, 16'h0001,   2, 32'h0000_8000, 1'b1};
    vecs[5]  = '{1'b1, 1'b1, 32'hFFFF_8000, 16'h0001,   2, 32'h0000_8000, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 32'hFFFF_FFF9, 16'h0002,   4, 32'hFFFF_FFFD, 1'b0};
    vecs[7]  = '{1'b1, 1'b1, 32'h0000_0007, 16'hFFFE,   1, 32'h0001_FFFD, 1'b0};
    vecs[8]  = '{1'b1, 0,    32'h0000_FF80, 16'h00FF,   2, 32'h0000_FF80, 1'b1};
    vecs[9]  = '{1'b1, 0,    32'h0000_FF80, 16'h0001,   2, 32'h0000_0080, 1'b0};
    vecs[10] = '{1'b0, 0,    32'h0000_FFFF, 16'h00FF,   3, 32'h0000_FFFF, 1'b1};
    vecs[11] = '{1'b0, 0,    32'h0000_0042, 16'h0100,   1, 32'h0000_0042, 1'b1};
    vecs[12] = '{1'b0, 1'b1, 32'h0010_0000, 16'h0001,   2, 32'h0010_0000, 1'b1};

    bus.req = 1'b0;
    bus.sign = 1'b0;
    bus.len = 1'b0;
    bus.dividend = 32'h0;
    bus.divisor = 16'h0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_busy",      {31'h0, bus.busy},      32'h0);
    chk("reset_done",      {31'h0, bus.done},      32'h0);
    chk("reset_v",         {31'h0, bus.v},         32'h0);
    chk("reset_div_start", {31'h0, bus.div_start}, 32'h0);
    chk("reset_result",    bus.result,             32'h0);
    chk("reset_div_op0",   bus.div_op0,            32'h0);
    chk("reset_div_op1",   {16'h0, bus.div_op1},   32'h0);
    chk("reset_div_len",   {31'h0, bus.div_len},   32'h0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    foreach (vecs[i])
      run_op(vecs[i].s, vecs[i].l, vecs[i].dd, vecs[i].dv, vecs[i].nb, vecs[i].res, vecs[i].v, 1'b0);

    cen_toggle = 1'b1;
    for (int i = 0; i < 6; i++)
      run_op(vecs[i].s, vecs[i].l, vecs[i].dd, vecs[i].dv, vecs[i].nb + 1, vecs[i].res, vecs[i].v, 1'b0);
    cen_toggle = 1'b0;
    repeat (2) @(negedge clk);

    run_op(1'b0, 1'b1, 32'd125, 16'd7, 6, 32'h0006_0011, 1'b0, 1'b1);

    begin
      int d0;
      push_exp(1'b0, 1'b1, 32'd125, 16'd7, 10, 32'h0006_0011, 1'b0);
      nbusy = 10;
      d0 = done_cnt;
      @(negedge clk);
      bus.sign = 1'b0;
      bus.len = 1'b1;
      bus.dividend = 32'd125;
      bus.divisor = 16'd7;
      bus.req = 1'b1;
      @(negedge clk);
      bus.req = 1'b0;
      for (int i = 0; i < 60 && !(bus.busy && !bus.div_start && bus.div_busy); i++) @(negedge clk);
      chk("reached_wait", {31'h0, bus.busy && !bus.div_start && bus.div_busy}, 32'h1);
      rst = 1'b1;
      @(negedge clk);
      chk("midop_reset_busy",  {31'h0, bus.busy},      32'h0);
      chk("midop_reset_start", {31'h0, bus.div_start}, 32'h0);
      chk("midop_reset_done",  {31'h0, bus.done},      32'h0);
      rst = 1'b0;
      exp_q.delete();
      repeat (30) @(negedge clk);
      chk("no_done_after_reset", done_cnt - d0, 0);
      $display("[TB] reset mid-op: busy=%0b start=%0b", bus.busy, bus.div_start);
    end

    run_op(1'b0, 1'b1, 32'd125, 16'd7, 3, 32'h0006_0011, 1'b0, 1'b0);
    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/jt900h_div_ctl.md
Name: jt900h_div_ctl

Overview:
Sequencer between the TLCS-900H instruction execution unit and the shared unsigned divider jt900h_div. It accepts DIV/DIVS requests in byte or word length and takes operand magnitudes for signed requests. It drives the divider start/busy handshake, applies the sign fix-up and signed-overflow check, and handles divide-by-zero without starting the divider. It returns a packed register-ready result plus the V flag.

Parameters:
None.

Ports:
clk       in   1   system clock
rst       in   1   synchronous reset, active-high
cen       in   1   clock enable; all state advances only when cen=1
req       in   1   start request; sampled in IDLE only
sign      in   1   1=DIVS (two's complement), 0=DIV (unsigned)
len       in   1   1=word (32/16), 0=byte (16/8)
dividend  in   32  byte mode uses [15:0]
divisor   in   16  byte mode uses [7:0]
busy      out  1   high from request acceptance until DONE exits
done      out  1   one cen-cycle pulse; result and v valid while high and held until next accept
result    out  32  len=1: {rem16,quot16}; len=0: {16'h0,rem8,quot8}; equals dividend when v=1
v         out  1   overflow or divide-by-zero
div_op0   out  32  divider dividend (magnitude)
div_op1   out  16  divider divisor (magnitude)
div_len   out  1   divider length
div_start out  1   divider start
div_quot  in   16  divider quotient
div_rem   in   16  divider remainder
div_busy  in   1   divider busy
div_v     in   1   divider unsigned overflow

Behaviour:
- Reset (any state, including mid-operation): state=IDLE, and busy, done, v, div_start are all 0. result and div_op0/div_op1 are 0. div_len=0.
- States: IDLE, PREP, START, WAIT, FIX, DONE.
- IDLE: on req&cen, latch sign, len, dividend and divisor, set busy=1, go to PREP. req in any other state is ignored.
- PREP (1 cycle): compute magnitudes.
  - Word: op0=|dividend[31:0]|, op1=|divisor|.
  - Byte: op0={16'h0,|dividend[15:0]|}, op1={8'h0,|divisor[7:0]|}.
  - Magnitude is taken only when sign=1. The most-negative value maps to its unsigned magnitude (e.g. 0x80000000 stays 0x80000000).
  - Record neg_q = sign & (sd^sv) and neg_r = sign & sd, where sd and sv are the operand MSBs for the selected length.
  - If the selected-width divisor is 0, set v=1 and result=dividend and go straight to DONE. div_start is never asserted in this case.
  - Otherwise go to START.
- START: div_start=1, held until div_busy=1 is sampled, then div_start=0 and go to WAIT.
- WAIT: remain until div_busy=0, then go to FIX.
- FIX (1 cycle): apply signs.
  - q = neg_q ? -div_quot : div_quot; r = neg_r ? -div_rem : div_rem, both at the selected width.
  - Signed overflow (sign=1): unsigned magnitude > 0x7FFF (word) or > 0x7F (byte) when the quotient is positive. When the quotient is negative, the limit is 0x8000 (word) or 0x80 (byte).
  - Byte unsigned overflow: div_v, or div_quot[15:8] != 0.
  - v = div_v | signed_ovf | byte_ovf. When v=1, result=latched dividend; otherwise result is packed as in Ports.
- DONE: done=1 for one cen cycle, busy=0 on exit, return to IDLE.
- Latency, unsigned non-zero divisor, div_busy rising one cen after start: done occurs (divider busy cycles + 5) cen cycles after req acceptance. Divide-by-zero: done 2 cen cycles after acceptance.
- cen=0: all outputs and state hold, including div_start.
- Remainder sign follows the dividend. The quotient truncates toward zero.

Test Plan:
1. Unsigned word: len=1, sign=0, dividend=125, divisor=7 -> div_op0=125, div_op1=7; done with result=0x0006_0011, v=0.
2. Signed byte: len=0, sign=1, dividend=0xFF83 (-125), divisor=0x07 -> div_op0=125; result=0x0000_FAEF (q=-17, r=-6), v=0.
3. Divide-by-zero: len=1, dividend=0x1234_5678, divisor=0 -> div_start stays 0; done 2 cen after accept; v=1, result=0x1234_5678.
4. Overflow: len=0, sign=0, dividend=0x1000, divisor=2 -> v=1, result=0x0000_1000. Also signed word dividend=0x0000_8000, divisor=1 -> v=1. Signed word dividend=0xFFFF_8000, divisor=1 -> v=0, result=0x0000_8000.
5. Handshake and gating:
   - req pulsed while busy is ignored (no second done).
   - cen toggling 1/0 stretches latency without changing results.
   - div_start drops on the cycle after div_busy=1 is sampled.
6. Reset mid-op: assert rst during WAIT -> next cycle busy=0, div_start=0, done never pulses. A new req after release completes test 1 correctly.
